rv64_iter_divider: RTL and testbench

- Multi-cycle RV64M divider/remainder unit for the CPU's EX/M stages.
- Covers DIV, DIVU, REM, REMU and their 32-bit W variants.
- Accepts one operation through a ready/valid handshake and iterates one quotient bit per cycle.
- Pulses out_valid with the final result; the pipeline stalls on ~in_ready.

---
 rtl/rv64_iter_divider_if.sv | 24 ++
 rtl/rv64_iter_divider.sv | 159 +++++++++++++++
 tb/tb_rv64_iter_divider.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rv64_iter_divider_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Operands in with in_valid/in_ready; out_valid pulses once with result.
interface rv64_iter_divider_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] src1_in;
  logic [XLEN-1:0] src2_in;
  logic            is_w;
  logic [1:0]      ALUctr_in;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output src1_in, src2_in, is_w, ALUctr_in, in_valid,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  src1_in, src2_in, is_w, ALUctr_in, in_valid,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/rv64_iter_divider.sv
// RV64M DIV/DIVU/REM/REMU(+W) restoring divider: N+1 busy cycles (N=64, W: 32), one-cycle out_valid.
// in_ready low while busy; optional DIV_EARLY_OUT_EN sends div-by-zero/overflow straight to DONE.
module rv64_iter_divider #(
  parameter int XLEN = 64
) (
  input logic               clk,
  input logic               rst,
  rv64_iter_divider_if.slave bus
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_q, w_d, remop_q, remop_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic            div0_q, div0_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

  // Operand preparation on the raw request
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic            sgn, a_neg, b_neg, div0_in, ovf_in;

  always_comb begin
    sgn   = ~bus.ALUctr_in[0];
    a_ext = bus.src1_in;
    b_ext = bus.src2_in;
    if (bus.is_w) begin
      a_ext = {{HALF{sgn & bus.src1_in[HALF-1]}}, bus.src1_in[HALF-1:0]};
      b_ext = {{HALF{sgn & bus.src2_in[HALF-1]}}, bus.src2_in[HALF-1:0]};
    end
    a_neg   = sgn & a_ext[XLEN-1];
    b_neg   = sgn & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    div0_in = (b_ext == '0);
    ovf_in  = sgn & (&b_ext) & (a_ext == (bus.is_w ? MIN_W : MIN_X));
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [XLEN:0] rem_sh, diff;
  logic          fits;

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    fits   = ~diff[XLEN];
  end

  logic [XLEN-1:0] q_fin, r_fin, res_x;

  always_comb begin
    q_fin = qneg_q ? -quo_q : quo_q;
    r_fin = rneg_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (ovf_q) begin
      q_fin = a_q;
      r_fin = '0;
    end
    res_x = remop_q ? r_fin : q_fin;
    if (w_q) res_x = {{HALF{res_x[HALF-1]}}, res_x[HALF-1:0]};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    remop_d     = remop_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = a_ext;
          // W dividends sit in the top half so the first shift sees their MSB
          quo_d   = bus.is_w ? (a_abs << HALF) : a_abs;
          rem_d   = '0;
          dvs_d   = b_abs;
          cnt_d   = '0;
          w_d     = bus.is_w;
          remop_d = bus.ALUctr_in[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          div0_d  = div0_in;
          ovf_d   = ovf_in;
`ifdef DIV_EARLY_OUT_EN
          state_d = (div0_in | ovf_in) ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        rem_d = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (w_q ? CW'(HALF - 1) : CW'(XLEN - 1))) state_d = DONE;
      end
      DONE: begin
        result_d    = res_x;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      w_q         <= 1'b0;
      remop_q     <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      remop_q     <= remop_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_rv64_iter_divider.sv
// Scoreboard bench for rv64_iter_divider: arithmetic reference model, latency and result checks.
module tb_rv64_iter_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   op_id = 0;

  rv64_iter_divider_if #(.XLEN(64)) bus();

  rv64_iter_divider #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: language-level signed/unsigned division plus the RISC-V special cases
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic w, input logic [1:0] ctl);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0)                                          r32 = ctl[1] ? a32 : 32'hFFFF_FFFF;
      else if (!ctl[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = ctl[1] ? 32'd0 : a32;
      else if (ctl[0])                                           r32 = ctl[1] ? a32 % b32 : a32 / b32;
      else if (ctl[1])                                           r32 = $signed(a32) % $signed(b32);
      else                                                       r32 = $signed(a32) / $signed(b32);
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                            r = ctl[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!ctl[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = ctl[1] ? 64'd0 : a;
      else if (ctl[0])                                           r = ctl[1] ? a % b : a / b;
      else if (ctl[1])                                           r = $signed(a) % $signed(b);
      else                                                       r = $signed(a) / $signed(b);
    end
    return r;
  endfunction

  // Called at a negedge; leaves in_valid low at the negedge after the accepting edge
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w, input logic [1:0] ctl);
    int   t;
    exp_t e;
    bus.src1_in   = a;
    bus.src2_in   = b;
    bus.is_w      = w;
    bus.ALUctr_in = ctl;
    bus.in_valid  = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end else begin
      e.res = ref_div(a, b, w, ctl);
      e.due = cyc + (w ? 32 : 64) + 2;
      e.id  = op_id++;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'hFFFF_FFFF_8000_0000;
      4: v = {32'd0, 32'h8000_0000};
      5: v = {32'd0, $urandom} >> $urandom_range(0, 31);
      6: v = {$urandom, 32'd0};
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: every out_valid pulse must match the head of the scoreboard in value and timing
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, required none pending", cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_op%0d", e.id), bus.result, e.res);
          chk($sformatf("latency_op%0d", e.id), 64'(cyc), 64'(e.due));
          chk($sformatf("ready_on_valid_op%0d", e.id), 64'(bus.in_ready), 64'd1);
        end
      end
    end
  end

  initial begin
    int t;
    bus.src1_in   = '0;
    bus.src2_in   = '0;
    bus.is_w      = 1'b0;
    bus.ALUctr_in = 2'b00;
    bus.in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_result", bus.result, 64'd0);

    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 2'b00);
    @(negedge clk);
    chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 2'b10);
    issue(64'h0000_0001_8000_0000, 64'd1, 1'b1, 2'b01);
    issue(64'd123, 64'd0, 1'b0, 2'b01);
    issue(64'd123, 64'd0, 1'b0, 2'b11);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'b10);
    issue(64'h0000_0000_0000_0064, 64'h0000_0000_0000_0000, 1'b1, 2'b10);

    // Abort: DIV 100/7 then reset 10 cycles in, with a request held during reset
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    issue(64'd100, 64'd7, 1'b0, 2'b00);
    repeat (9) @(negedge clk);
    bus.src1_in  = 64'd55;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_result", bus.result, 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    issue(64'd100, 64'd7, 1'b0, 2'b11);

    // Random traffic, some back-to-back with in_valid held high
    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 80)) @(negedge clk);
    end

    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
